uart_tx_fifo: RTL
=================

# uart_tx_fifo

Parametrised UART transmitter with an internal transmit FIFO, runtime-programmable baud divisor, and runtime-selectable parity and stop-bit count. It generalises the existing fixed 8-bit, single-stop `uart_tx`. It accepts words over a valid/ready stream and serialises them back-to-back onto `tx`. The output drives the existing `uart_rx` line input, or a pad.

## Interface
- `DATA_W`, default 8: data bits per frame, legal range 5..9.
- `FIFO_DEPTH`, default 8: FIFO entries; must be a power of two, at least 2.
- `DIV_W`, default 16: width of the baud divisor.

- `clk`  in  1: system clock; all state is on the rising edge.
- `reset`  in  1: asynchronous, active-low reset. 0 = in reset.
- `baud_div`  in  DIV_W: clocks per bit. Values below 2 are treated as 2.
- `parity_en`  in  1: 1 inserts a parity bit after the data bits.
- `parity_odd`  in  1: 1 = odd parity, 0 = even; ignored when `parity_en`=0.
- `two_stop`  in  1: 1 = two stop bits, 0 = one.
- `in_data`  in  DATA_W: word to transmit.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: FIFO can accept a word; equals `fifo_count` < FIFO_DEPTH.
- `tx`  out  1: serial line, idles high.
- `busy`  out  1: a frame is in progress (FSM not in IDLE).
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1: words currently queued.

## Operation
- **Push:** a word is written when `in_valid` && `in_ready` at a clock edge. With `in_ready`=0, `in_data` is not written and must be held by the source.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
- **IDLE:** if `fifo_count` > 0, pop the head word and latch `baud_div`, `parity_en`, `parity_odd` and `two_stop` into frame registers, then go to START. Otherwise stay in IDLE with `tx`=1.
- **START:** `tx`=0 for one bit time.
- **DATA:** shift out DATA_W bits, LSB first, one bit time each.
- **PARITY:** entered only if latched `parity_en`=1.
  - Even parity: bit = XOR of the data bits.
  - Odd parity: bit = inverted XOR of the data bits.
- **STOP:** `tx`=1 for 1 or 2 bit times, per latched `two_stop`.
- **End of stop:** on the last cycle of the last stop bit, if the FIFO is non-empty, pop and enter START on the next edge with no idle gap. Otherwise return to IDLE.
- **Bit timing:** one bit time is exactly max(`baud_div`, 2) clocks, counted by a down-counter reloaded at each bit boundary.
- **Frame length:** max(`baud_div`, 2) × (1 + DATA_W + `parity_en` + 1 + `two_stop`) clocks.
- **Config changes mid-frame:** changes to `baud_div`, `parity_en`, `parity_odd` or `two_stop` during a frame have no effect until the next frame latches them.
- **FIFO:** circular buffer with wrap-around pointers, not fall-through. A pop only happens from a registered entry.
- **Simultaneous push and pop:** `fifo_count` is unchanged and both pointers advance.
- **Full FIFO:** `in_ready`=0, so no push occurs that cycle even if a pop happens in the same cycle.

## Timing
- **Reset values:**
  - `tx`=1, `busy`=0, `in_ready`=1, `fifo_count`=0.
  - FSM in IDLE, FIFO pointers at 0.
- **Reset behaviour:** reset takes effect immediately and asynchronously, including mid-frame. `tx` returns high at once and queued words are discarded. Release is synchronous to `clk`.
- **Latency:** with an empty, idle transmitter and a word pushed at edge E:
  - After E: `fifo_count`=1.
  - At edge E+1: pop occurs; `tx`=0, `busy`=1, `fifo_count`=0.
- **`busy`:** drops on the edge that returns the FSM to IDLE, which is exactly one frame length after the start-bit edge.
- **`in_ready`:** updates the cycle after the count changes (registered count, combinational compare).

## Test plan
- **Reset values:** hold `reset`=0, then release with `in_valid`=0 → `tx`=1, `busy`=0, `in_ready`=1, `fifo_count`=0 for 20 cycles.
- **Basic frame:** DATA_W=8, `baud_div`=4, no parity, 1 stop; push 0xA5 → `tx` = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. Start bit begins 2 edges after the push is presented; `busy` is high for exactly 40 cycles.
- **Parity:** `parity_en`=1, push 0x07 with `parity_odd`=0 → parity bit 1; repeat with `parity_odd`=1 → parity bit 0. Frame is 11 bit times.
- **Back-pressure and back-to-back frames:** FIFO_DEPTH=8, `baud_div`=16, `in_valid` held high with 12 incrementing words →
  - First word pops, 8 more fill the FIFO, then `in_ready`=0.
  - Further words are accepted one per completed frame.
  - Start bits are spaced exactly 160 clocks apart.
  - All 12 words are received in order by `uart_rx`.
- **Mid-frame config change and two stop bits:** DATA_W=9, `two_stop`=1, `baud_div`=3; change `baud_div` to 8 mid-frame → current frame keeps 3 clocks/bit, with 2 stop bits (36 cycles total). The next frame uses 8 clocks/bit.
- **Reset mid-frame:** assert `reset`=0 during the DATA state with 3 words queued → `tx`=1 asynchronously and `fifo_count`=0. After release, no frame is sent until a new push.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a circular transmit FIFO. Baud divisor, parity and
// stop-bit count are programmable and are latched at the start of each frame.
module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic                          parity_en,
  input  logic                          parity_odd,
  input  logic                          two_stop,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              push, pop;

  logic [DIV_W-1:0]  div_eff;
  logic [DIV_W-1:0]  div_q, cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic [BW-1:0]     bit_idx_q;
  logic              stop_idx_q;
  logic              par_en_q, par_bit_q, two_stop_q;
  logic              tick;

  assign in_ready   = count_q < CW'(FIFO_DEPTH);
  assign push       = in_valid && in_ready;
  assign fifo_count = count_q;
  assign busy       = (state_q != S_IDLE);
  assign div_eff    = (baud_div < DIV_W'(2)) ? DIV_W'(2) : baud_div;
  assign tick       = (cnt_q == '0);

  // NOTE: storage has no reset; only pointers and count define its contents,
  // so clearing them discards every queued word.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples values from before the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block is defaulted first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    tx      = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        tx = 1'b0;
        if (tick) state_d = S_DATA;
      end
      S_DATA: begin
        tx = shift_q[0];
        if (tick && bit_idx_q == BW'(DATA_W - 1))
          state_d = par_en_q ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        tx = par_bit_q;
        if (tick) state_d = S_STOP;
      end
      S_STOP: begin
        // Last cycle of the last stop bit chains straight into the next frame.
        if (tick && (stop_idx_q == two_stop_q)) begin
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q      <= '0;
      cnt_q      <= '0;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
    end else if (pop) begin
      shift_q    <= mem[rd_ptr_q];
      par_bit_q  <= (^mem[rd_ptr_q]) ^ parity_odd;
      par_en_q   <= parity_en;
      two_stop_q <= two_stop;
      div_q      <= div_eff;
      cnt_q      <= div_eff - 1'b1;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
    end else if (state_q != S_IDLE) begin
      if (tick) begin
        cnt_q <= div_q - 1'b1;
        if (state_q == S_DATA) begin
          shift_q   <= shift_q >> 1;
          bit_idx_q <= bit_idx_q + 1'b1;
        end
        if (state_q == S_STOP) stop_idx_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule
